systolic_tile_sequencer: RTL and testbench
==========================================

# systolic_tile_sequencer

Single-clock controller that sequences one weight tile through the 4x4 systolic array. On a start command it clears the PE accumulators, pops a programmed number of weight rows from the weight buffer, and freezes the array whenever the buffer runs dry. It then drains the skewed pipeline and pulses done. It sits between the host control registers and the weight buffer read side and array enable.

## Interface
- ARRAY_DIM, 4, systolic array edge length; sets drain length.
- CNT_W, 10, width of row count and issue counter.
- axi_clk  in  1  clock; all logic on rising edge.
- axi_rst  in  1  asynchronous, active-high reset.
- start  in  1  command pulse; accepted only in IDLE.
- num_rows  in  CNT_W  rows to stream; captured on accepted start.
- buf_avail  in  1  weight buffer holds at least one unread word.
- rd_en  out  1  pop one weight word this cycle.
- acc_clr  out  1  one-cycle accumulator clear pulse.
- array_en  out  1  systolic array advances this cycle.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle tile-complete pulse.
- rows_issued  out  CNT_W  words popped since the last accepted start.
- stall_cnt  out  16  STREAM stall cycles; present only with SEQ_STALL_CNT_EN.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE. Encoding is free; outputs are decoded from the state register plus buf_avail.
- IDLE: when start=1 and num_rows≠0, latch num_rows, clear rows_issued, and go to CLEAR. When start=1 and num_rows=0, go straight to DONE with no clear and no reads.
- CLEAR: acc_clr=1 for one cycle, then go to STREAM.
- STREAM:
  - rd_en = array_en = buf_avail.
  - rows_issued increments on each rd_en.
  - When rd_en=1 and rows_issued = latched−1, go to DRAIN.
  - When buf_avail=0, the array is frozen (array_en=0) and the FSM stays in STREAM.
- DRAIN:
  - array_en=1 and rd_en=0 for exactly 2*ARRAY_DIM−1 cycles: ARRAY_DIM−1 cycles of skew plus ARRAY_DIM cycles of propagation.
  - A drain counter runs from 0; at 2*ARRAY_DIM−2, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored. This includes the DONE cycle, and num_rows is not re-latched.
- rows_issued holds its value after DONE until the next accepted start.
- Counter widths: rows_issued is CNT_W bits and never wraps, because it is bounded by num_rows ≤ 2^CNT_W−1. The drain counter is clog2(2*ARRAY_DIM) bits.

## Timing
- Reset values: rd_en, acc_clr, array_en, busy, done = 0; rows_issued = 0; stall_cnt = 0; state = IDLE.
- Reset asserted mid-tile returns everything to the reset values immediately. The tile is abandoned and no done is pulsed.
- Cycle numbering: start is sampled at edge 0.
  - CLEAR occupies cycle 1.
  - STREAM begins at cycle 2.
- With buf_avail held at 1 and N rows:
  - rd_en is high for cycles 2..N+1.
  - DRAIN occupies cycles N+2..N+2*ARRAY_DIM.
  - done is high at cycle N+2*ARRAY_DIM+1 (N+9 for ARRAY_DIM=4).
- Each STREAM cycle with buf_avail=0 delays done by one cycle.
- busy is high from cycle 1 through the done cycle inclusive.
- num_rows=0 case: done at cycle 1, busy high only in that cycle.
- rd_en and array_en follow buf_avail combinationally within STREAM. The buffer must present buf_avail from registered state.

## Configuration
- SEQ_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - It increments on each STREAM cycle with buf_avail=0.
  - It saturates at 16'hFFFF and clears on accepted start.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then start with num_rows=5 and buf_avail=1:
  - acc_clr at cycle 1.
  - rd_en at cycles 2–6.
  - array_en at cycles 2–13.
  - done at cycle 14; rows_issued=5.
- num_rows=4 with buf_avail low at cycles 3–5:
  - rd_en stays low for those cycles.
  - done at cycle 16.
  - stall_cnt=3 when the macro is enabled.
- num_rows=0: done at cycle 1, no acc_clr and no rd_en, rows_issued=0.
- start pulsed during STREAM and during DONE: ignored; num_rows change has no effect; exactly one done.
- axi_rst asserted at cycle 4 of a 10-row tile:
  - All outputs go to 0 and state is IDLE.
  - A new start with num_rows=2 completes with done at cycle 11.
- num_rows=1023, buf_avail=1: rows_issued=1023 and done at cycle 1032.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : systolic_tile_sequencer                                       |
// | Purpose  : Sequences one weight tile through the systolic array: clears  |
// |            accumulators, pops programmed weight rows (freezing while the |
// |            buffer is empty), drains the skewed pipeline, pulses done.    |
// | Options  : SEQ_STALL_CNT_EN adds the 16-bit saturating stall_cnt output. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module systolic_tile_sequencer #(
  parameter int ARRAY_DIM = 4,
  parameter int CNT_W     = 10
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic             buf_avail,
  output logic             rd_en,
  output logic             acc_clr,
  output logic             array_en,
  output logic             busy,
  output logic             done,
`ifdef SEQ_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic [CNT_W-1:0] rows_issued
);

  localparam int               DRN_W      = $clog2(2 * ARRAY_DIM);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(2 * ARRAY_DIM - 2);
  localparam logic [DRN_W-1:0] DRN_ONE    = DRN_W'(1);
  localparam logic [CNT_W-1:0] ROW_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_rows_q, num_rows_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             start_accept;

  // A start is only honoured while idle; every other state ignores it.
  assign start_accept = (state_q == S_IDLE) && start;
  assign busy         = (state_q != S_IDLE);
  assign rows_issued  = rows_q;

  // State register and datapath counters.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      rows_q     <= '0;
      drn_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      rows_q     <= rows_d;
      drn_q      <= drn_d;
    end
  end

  // Next-state and output decode from the state register plus buf_avail.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    acc_clr  = 1'b0;
    array_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero-row tile skips the clear and the reads entirely.
          state_d = (num_rows != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // An empty buffer freezes the array rather than feeding it bubbles.
        rd_en    = buf_avail;
        array_en = buf_avail;
        if (buf_avail && (rows_q == (num_rows_q - ROW_ONE))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        array_en = 1'b1;
        if (drn_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Row latch, issue counter and drain counter next values.
  always_comb begin
    num_rows_d = num_rows_q;
    rows_d     = rows_q;
    if (start_accept) begin
      num_rows_d = num_rows;
      rows_d     = '0;
    end else if (rd_en) begin
      rows_d = rows_q + ROW_ONE;
    end
    // Counts drain cycles from zero; held at zero outside DRAIN.
    drn_d = (state_q == S_DRAIN) ? (drn_q + DRN_ONE) : '0;
  end

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of STREAM cycles spent waiting on the buffer.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      stall_q <= '0;
    end else if (start_accept) begin
      stall_q <= '0;
    end else if ((state_q == S_STREAM) && !buf_avail && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_systolic_tile_sequencer                                    |
// | Purpose  : Self-checking bench for systolic_tile_sequencer. Per-cycle    |
// |            output vectors come from the documented timing formulas; tile |
// |            completions are checked against a scoreboard queue.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_systolic_tile_sequencer;

  localparam int AD = 4;
  localparam int CW = 10;

  logic          axi_clk;
  logic          axi_rst;
  logic          start;
  logic [CW-1:0] num_rows;
  logic          buf_avail;
  logic          rd_en;
  logic          acc_clr;
  logic          array_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] rows_issued;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  systolic_tile_sequencer #(.ARRAY_DIM(AD), .CNT_W(CW)) dut (
    .axi_clk    (axi_clk),
    .axi_rst    (axi_rst),
    .start      (start),
    .num_rows   (num_rows),
    .buf_avail  (buf_avail),
    .rd_en      (rd_en),
    .acc_clr    (acc_clr),
    .array_en   (array_en),
    .busy       (busy),
    .done       (done),
`ifdef SEQ_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .rows_issued(rows_issued)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    int            done_cyc;
    logic [CW-1:0] rows;
    logic [15:0]   stalls;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {acc_clr, rd_en, array_en, busy, done} for cycle c of a tile.
  function automatic logic [4:0] exp_vec(input int c, input int n, input int lo, input int hi);
    int s, dc;
    logic acc, rd, ae, bz, dn, stl, strm, drn;
    s = (lo > 0) ? (hi - lo + 1) : 0;
    if (n == 0) return (c == 1) ? 5'b00011 : 5'b00000;
    dc   = n + 2 * AD + 1 + s;
    acc  = (c == 1);
    stl  = (lo > 0) && (c >= lo) && (c <= hi);
    strm = (c >= 2) && (c <= n + 1 + s);
    drn  = (c >= n + 2 + s) && (c <= n + 2 * AD + s);
    rd   = strm && !stl;
    ae   = rd || drn;
    bz   = (c >= 1) && (c <= dc);
    dn   = (c == dc);
    return {acc, rd, ae, bz, dn};
  endfunction

  // One tile: n rows, buffer empty for cycles lo..hi (lo=0: never),
  // optional stray start at cycle gc with row count gn, optional stray
  // start during the done cycle, optional reset at cycle rc (0: none).
  task automatic run_tile(input int n, input int lo, input int hi, input int gc,
                          input int gn, input bit gdone, input int rc);
    int   s, exp_done;
    bit   aborted;
    exp_t e;
    s        = (lo > 0) ? (hi - lo + 1) : 0;
    exp_done = (n == 0) ? 1 : (n + 2 * AD + 1 + s);
    aborted  = 1'b0;
    @(posedge axi_clk); #1;
    start     = 1'b1;
    num_rows  = CW'(n);
    buf_avail = 1'b1;
    e.done_cyc = exp_done;
    e.rows     = CW'(n);
    e.stalls   = 16'(s);
    sb.push_back(e);
    @(posedge axi_clk); #1;
    for (int c = 1; c <= exp_done + 2; c++) begin
      start    = 1'b0;
      num_rows = CW'(n);
      if (c == gc) begin
        start    = 1'b1;
        num_rows = CW'(gn);
      end
      if (gdone && (c == exp_done)) begin
        start    = 1'b1;
        num_rows = CW'(n + 3);
      end
      buf_avail = !((lo > 0) && (c >= lo) && (c <= hi));
      if (c == rc) begin
        axi_rst = 1'b1;
        #1;
        chk("rst_outs", 32'({acc_clr, rd_en, array_en, busy, done}), 32'd0);
        chk("rst_rows", 32'(rows_issued), 32'd0);
        sb.delete();
        @(negedge axi_clk);
        axi_rst = 1'b0;
        start   = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(negedge axi_clk);
      chk("outs", 32'({acc_clr, rd_en, array_en, busy, done}), 32'(exp_vec(c, n, lo, hi)));
      if (done) begin
        chk("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_cycle", 32'(c), 32'(e.done_cyc));
          chk("rows_at_done", 32'(rows_issued), 32'(e.rows));
`ifdef SEQ_STALL_CNT_EN
          chk("stall_cnt", 32'(stall_cnt), 32'(e.stalls));
`endif
        end
      end
      @(posedge axi_clk); #1;
    end
    start = 1'b0;
    if (!aborted) begin
      chk("done_missing", 32'(sb.size()), 32'd0);
      chk("rows_hold", 32'(rows_issued), 32'(n));
      sb.delete();
    end
  endtask

  initial begin
    axi_rst   = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    buf_avail = 1'b0;
    repeat (2) @(posedge axi_clk);
    #1;
    chk("reset_outs", 32'({acc_clr, rd_en, array_en, busy, done}), 32'd0);
    chk("reset_rows", 32'(rows_issued), 32'd0);
`ifdef SEQ_STALL_CNT_EN
    chk("reset_stall", 32'(stall_cnt), 32'd0);
`endif
    axi_rst = 1'b0;

    // Basic 5-row tile, buffer always ready: done at cycle 14.
    run_tile(5, 0, 0, 0, 0, 1'b0, 0);
    // 4 rows with buffer empty during cycles 3..5: done at cycle 16.
    run_tile(4, 3, 5, 0, 0, 1'b0, 0);
    // Zero-row tile: done at cycle 1, nothing else.
    run_tile(0, 0, 0, 0, 0, 1'b0, 0);
    // Stray starts during STREAM and DONE are ignored.
    run_tile(6, 0, 0, 3, 2, 1'b1, 0);
    // Reset at cycle 4 of a 10-row tile, then a 2-row tile (done at 11).
    run_tile(10, 0, 0, 0, 0, 1'b0, 4);
    run_tile(2, 0, 0, 0, 0, 1'b0, 0);
    // Full-scale tile: done at cycle 1032.
    run_tile(1023, 0, 0, 0, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
